// File: rtl/io_port_bridge_pkg.sv
// ============================================================================
//  Module      : io_port_bridge_pkg
//  Description : I/O window address map and STATUS register bit layout for
//                the CPU-side switch/HEX port bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package io_port_bridge_pkg;

    // Byte offsets within the I/O window; only addr[7:0] is decoded.
    localparam logic [7:0] OUT0_A = 8'h80;
    localparam logic [7:0] OUT1_A = 8'h84;
    localparam logic [7:0] OUT2_A = 8'h88;
    localparam logic [7:0] IN0_A  = 8'hC0;
    localparam logic [7:0] IN1_A  = 8'hC4;
    localparam logic [7:0] STAT_A = 8'hCC;

    localparam int STAT_W       = 2;
    localparam int STAT_IN0_BIT = 0;
    localparam int STAT_IN1_BIT = 1;

endpackage

`default_nettype wire

// File: rtl/io_port_bridge_if.sv
// ============================================================================
//  Module      : io_port_bridge_if
//  Description : CPU data-bus view of the I/O window (store/load strobes,
//                address, write data and combinational read data).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_port_bridge_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic              we;
    logic              re;
    logic [DATA_W-1:0] rdata;

    modport master (
        output addr,
        output wdata,
        output we,
        output re,
        input  rdata
    );

    modport slave (
        input  addr,
        input  wdata,
        input  we,
        input  re,
        output rdata
    );
endinterface

`default_nettype wire

// File: rtl/io_port_bridge_debouncer.sv
// ============================================================================
//  Module      : io_port_bridge_debouncer
//  Description : Two-flop synchroniser plus stability counter for one switch
//                group; commits the whole word at once and pulses chg.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_bridge_debouncer #(
    parameter int SW_W         = 5,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [SW_W-1:0] raw,
    output logic [SW_W-1:0] stable,
    output logic            chg
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic [SW_W-1:0]  sync1_q,  sync1_d;
    logic [SW_W-1:0]  sync2_q,  sync2_d;
    logic [SW_W-1:0]  stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             w_chg;

    // Any return to the committed value restarts the count, so a bouncing
    // input never reaches CNT_MAX.
    always_comb begin
        sync1_d  = raw;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        w_chg    = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            w_chg    = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign chg    = w_chg;

endmodule

`default_nettype wire

// File: rtl/io_port_bridge.sv
// ============================================================================
//  Module      : io_port_bridge
//  Description : Memory-mapped responder holding three output port registers,
//                two debounced switch input ports and a sticky STATUS word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_port_bridge
    import io_port_bridge_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 5,
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic              clk,
    input  logic              resetn,
    io_port_bridge_if.slave   bus,
    input  logic [SW_W-1:0]   sw_in0,
    input  logic [SW_W-1:0]   sw_in1,
    output logic [DATA_W-1:0] out_port0,
    output logic [DATA_W-1:0] out_port1,
    output logic [DATA_W-1:0] out_port2
);

    logic [DATA_W-1:0] out0_q, out0_d;
    logic [DATA_W-1:0] out1_q, out1_d;
    logic [DATA_W-1:0] out2_q, out2_d;
    logic [STAT_W-1:0] stat_q, stat_d;

    logic [SW_W-1:0]   w_in0;
    logic [SW_W-1:0]   w_in1;
    logic              w_chg0;
    logic              w_chg1;
    logic [7:0]        w_off;
    logic              w_stat_clr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_addr;

    io_port_bridge_debouncer #(
        .SW_W         (SW_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb0 (
        .clk    (clk),
        .resetn (resetn),
        .raw    (sw_in0),
        .stable (w_in0),
        .chg    (w_chg0)
    );

    io_port_bridge_debouncer #(
        .SW_W         (SW_W),
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_deb1 (
        .clk    (clk),
        .resetn (resetn),
        .raw    (sw_in1),
        .stable (w_in1),
        .chg    (w_chg1)
    );

    assign w_off         = bus.addr[7:0];
    assign w_unused_addr = ^bus.addr[31:8];
    assign w_stat_clr    = bus.re && (w_off == STAT_A);

    always_comb begin
        out0_d = out0_q;
        out1_d = out1_q;
        out2_d = out2_q;
        if (bus.we) begin
            case (w_off)
                OUT0_A:  out0_d = bus.wdata;
                OUT1_A:  out1_d = bus.wdata;
                OUT2_A:  out2_d = bus.wdata;
                default: ;
            endcase
        end
    end

    // A change pulse on the same edge as a clearing read keeps the flag set.
    always_comb begin
        stat_d = w_stat_clr ? '0 : stat_q;
        stat_d[STAT_IN0_BIT] = stat_d[STAT_IN0_BIT] | w_chg0;
        stat_d[STAT_IN1_BIT] = stat_d[STAT_IN1_BIT] | w_chg1;
    end

    always_comb begin
        w_rdata = '0;
        if (bus.re) begin
            case (w_off)
                OUT0_A:  w_rdata = out0_q;
                OUT1_A:  w_rdata = out1_q;
                OUT2_A:  w_rdata = out2_q;
                IN0_A:   w_rdata = DATA_W'(w_in0);
                IN1_A:   w_rdata = DATA_W'(w_in1);
                STAT_A:  w_rdata = DATA_W'(stat_q);
                default: w_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out0_q <= '0;
            out1_q <= '0;
            out2_q <= '0;
            stat_q <= '0;
        end else begin
            out0_q <= out0_d;
            out1_q <= out1_d;
            out2_q <= out2_d;
            stat_q <= stat_d;
        end
    end

    assign bus.rdata = w_rdata;
    assign out_port0 = out0_q;
    assign out_port1 = out1_q;
    assign out_port2 = out2_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_bridge.sv
// ============================================================================
//  Module      : tb_io_port_bridge
//  Description : Directed, table-driven bench for io_port_bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_port_bridge;

    localparam int DATA_W = 32;
    localparam int SW_W   = 5;
    localparam int DEB    = 16;

    logic              clk;
    logic              resetn;
    logic [SW_W-1:0]   sw_in0;
    logic [SW_W-1:0]   sw_in1;
    logic [DATA_W-1:0] out_port0;
    logic [DATA_W-1:0] out_port1;
    logic [DATA_W-1:0] out_port2;

    int total;
    int bad;

    io_port_bridge_if #(.DATA_W(DATA_W)) bus ();

    io_port_bridge #(
        .DATA_W       (DATA_W),
        .SW_W         (SW_W),
        .DEBOUNCE_CYC (DEB)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .sw_in0    (sw_in0),
        .sw_in1    (sw_in1),
        .out_port0 (out_port0),
        .out_port1 (out_port1),
        .out_port2 (out_port2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [31:0] exp_o0;
        logic [31:0] exp_o1;
        logic [31:0] exp_o2;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Combinational load with no edge taken while re is high.
    task automatic rd_peek(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus.addr = a;
        bus.re   = 1'b1;
        #1;
        chk(nm, bus.rdata, exp);
        bus.re   = 1'b0;
        bus.addr = '0;
    endtask

    // Load held across one clock edge (clear-on-read takes effect).
    task automatic rd_cyc(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus.addr = a;
        bus.re   = 1'b1;
        #1;
        chk(nm, bus.rdata, exp);
        tick();
        bus.re   = 1'b0;
        bus.addr = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        vecs[0]  = '{1'b1, 1'b0, 32'h80,  32'h0000_0012, 32'h0,          32'h12, 32'h0,          32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h88,  32'hDEAD_BEEF, 32'h0,          32'h12, 32'h0,          32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 1'b1, 32'h80,  32'h0,         32'h12,         32'h12, 32'h0,          32'hDEAD_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 32'h88,  32'h0,         32'hDEAD_BEEF,  32'h12, 32'h0,          32'hDEAD_BEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h84,  32'h0,         32'h0,          32'h12, 32'h0,          32'hDEAD_BEEF};
        vecs[5]  = '{1'b1, 1'b1, 32'h84,  32'hCAFE_0001, 32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[6]  = '{1'b0, 1'b1, 32'h184, 32'h0,         32'hCAFE_0001,  32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[7]  = '{1'b1, 1'b0, 32'hC0,  32'h0000_FFFF, 32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[8]  = '{1'b0, 1'b1, 32'hC0,  32'h0,         32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[9]  = '{1'b1, 1'b1, 32'h90,  32'h55,        32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[10] = '{1'b1, 1'b0, 32'h81,  32'h77,        32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 1'b0, 32'hCC,  32'h3,         32'h0,          32'h12, 32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[12] = '{1'b1, 1'b0, 32'h80,  32'h0,         32'h0,          32'h0,  32'hCAFE_0001,  32'hDEAD_BEEF};
        vecs[13] = '{1'b0, 1'b0, 32'h88,  32'h0,         32'h0,          32'h0,  32'hCAFE_0001,  32'hDEAD_BEEF};

        // Reset with all switches high
        resetn     = 1'b0;
        sw_in0     = 5'h1F;
        sw_in1     = 5'h1F;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus.we     = 1'b0;
        bus.re     = 1'b0;
        tick();
        tick();
        chk("rst_out0", out_port0, 32'h0);
        chk("rst_out1", out_port1, 32'h0);
        chk("rst_out2", out_port2, 32'h0);
        rd_peek(32'hC0, 32'h0, "rst_in0");
        rd_peek(32'hC4, 32'h0, "rst_in1");
        rd_peek(32'hCC, 32'h0, "rst_stat");
        resetn = 1'b1;
        sw_in0 = '0;
        sw_in1 = '0;

        // Bus vectors: rdata checked before the edge, ports after it
        for (int i = 0; i < 14; i++) begin
            bus.we    = vecs[i].we;
            bus.re    = vecs[i].re;
            bus.addr  = vecs[i].addr;
            bus.wdata = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_rdata", i), bus.rdata, vecs[i].exp_rd);
            tick();
            bus.we = 1'b0;
            bus.re = 1'b0;
            chk($sformatf("vec%0d_out0", i), out_port0, vecs[i].exp_o0);
            chk($sformatf("vec%0d_out1", i), out_port1, vecs[i].exp_o1);
            chk($sformatf("vec%0d_out2", i), out_port2, vecs[i].exp_o2);
        end

        // Clean step on group 0 commits after DEB+2 edges
        sw_in0 = 5'h0B;
        for (int k = 1; k <= DEB + 2; k++) begin
            tick();
            rd_peek(32'hC0, (k <= DEB + 1) ? 32'h0 : 32'h0000_000B, $sformatf("step_in0_e%0d", k));
            rd_peek(32'hCC, (k <= DEB + 1) ? 32'h0 : 32'h1, $sformatf("step_stat_e%0d", k));
        end

        // Clear-on-read, then change landing on the clearing edge
        rd_cyc(32'hCC, 32'h1, "stat_rd1");
        rd_peek(32'hCC, 32'h0, "stat_rd2");
        sw_in0 = 5'h04;
        for (int k = 1; k <= DEB + 1; k++) tick();
        rd_peek(32'hC0, 32'h0000_000B, "pre_commit_in0");
        rd_cyc(32'hCC, 32'h0, "stat_clr_commit");
        rd_peek(32'hCC, 32'h1, "stat_set_wins");
        rd_peek(32'hC0, 32'h4, "commit_in0");
        rd_cyc(32'hCC, 32'h1, "stat_rd3");

        // Bouncing group 1 never commits
        for (int g = 0; g < 25; g++) begin
            sw_in1 = (g % 2 == 0) ? 5'h03 : 5'h00;
            for (int c = 0; c < 4; c++) tick();
            if (g % 5 == 4) rd_peek(32'hC4, 32'h0, $sformatf("bounce_in1_g%0d", g));
        end
        sw_in1 = 5'h00;
        for (int c = 0; c < DEB + 4; c++) tick();
        rd_peek(32'hC4, 32'h0, "bounce_in1_end");
        rd_peek(32'hCC, 32'h0, "bounce_stat");

        // Reset part-way through a debounce on group 1
        sw_in1 = 5'h1A;
        for (int k = 1; k <= DEB; k++) tick();
        rd_peek(32'hC4, 32'h0, "mid_in1");
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        sw_in0 = '0;
        sw_in1 = '0;
        chk("mid_rst_out1", out_port1, 32'h0);
        rd_peek(32'hC0, 32'h0, "mid_rst_in0");
        rd_peek(32'hC4, 32'h0, "mid_rst_in1");
        rd_peek(32'hCC, 32'h0, "mid_rst_stat");
        for (int k = 0; k < DEB + 4; k++) tick();
        rd_peek(32'hC4, 32'h0, "mid_late_in1");
        rd_peek(32'hCC, 32'h0, "mid_late_stat");

        bus.we    = 1'b1;
        bus.addr  = 32'hC0;
        bus.wdata = 32'h1234_5678;
        tick();
        bus.we = 1'b0;
        rd_peek(32'hC0, 32'h0, "in0_after_store");
        rd_peek(32'h90, 32'h0, "unmapped_rd");
        chk("store_in_out0", out_port0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
